// File: rtl/dsa_pixel_store_simd.sv
// -----------------------------------------------------------------------------
// dsa_pixel_store_simd
// Write-back engine for the SIMD bilinear datapath. One request carries
// SIMD_WIDTH interpolated pixels for horizontally adjacent destination
// coordinates (dst_x+k, dst_y). The group is written to a byte-wide output
// RAM port, one byte per cycle. Lanes that fall outside the destination
// image are dropped.
//
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   req_valid/ready   - request handshake (ready only while idle)
//   pix_in[k]         - pixel for destination x = dst_x + k
//   dst_x, dst_y      - destination coordinate of lane 0
//   img_base_addr     - byte address of output pixel (0,0)
//   out_width/height  - destination image size in pixels
//   mem_write_en/addr/wdata - registered write port, held while mem_wait=1
//   mem_wait          - memory stall, the presented write is not accepted
//   store_done        - one-cycle pulse when a group is finished
//   clipped           - with store_done: fewer than SIMD_WIDTH lanes written
//   busy              - high whenever not idle
// -----------------------------------------------------------------------------
module dsa_pixel_store_simd #(
  parameter int ADDR_WIDTH = 18,
  parameter int SIMD_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [7:0]            pix_in [0:SIMD_WIDTH-1],
  input  logic [15:0]           dst_x,
  input  logic [15:0]           dst_y,
  input  logic [ADDR_WIDTH-1:0] img_base_addr,
  input  logic [15:0]           out_width,
  input  logic [15:0]           out_height,
  output logic                  mem_write_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_wdata,
  input  logic                  mem_wait,
  output logic                  store_done,
  output logic                  clipped,
  output logic                  busy
);

  // Wide enough to hold the lane count 0..SIMD_WIDTH.
  localparam int CW = $clog2(SIMD_WIDTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ADDR  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t                  state_r;
  state_t                  state_nxt_s;

  // Captured request
  logic [7:0]              pix_r [0:SIMD_WIDTH-1];
  logic [15:0]             dst_x_r;
  logic [15:0]             dst_y_r;
  logic [ADDR_WIDTH-1:0]   base_r;
  logic [15:0]             width_r;
  logic [CW-1:0]           n_r;

  // Working registers
  logic [CW-1:0]           lane_r;
  logic [ADDR_WIDTH-1:0]   row_addr_r;

  // Next-state values
  logic                    capture_s;
  logic [CW-1:0]           n_in_s;
  logic [15:0]             diff_s;
  logic [CW-1:0]           lane_nxt_s;
  logic [CW-1:0]           lane_plus_s;
  logic [ADDR_WIDTH-1:0]   row_addr_nxt_s;
  logic [ADDR_WIDTH-1:0]   row_addr_s;
  logic [31:0]             prod_s;
  logic [ADDR_WIDTH+31:0]  prod_ext_s;
  logic [ADDR_WIDTH+15:0]  x_ext_s;
  logic [ADDR_WIDTH+CW-1:0] lane_ext_s;
  logic [7:0]              pix_plus_s;
  logic                    we_nxt_s;
  logic [ADDR_WIDTH-1:0]   addr_nxt_s;
  logic [7:0]              wdata_nxt_s;
  logic                    done_nxt_s;
  logic                    clipped_nxt_s;

  assign req_ready = (state_r == ST_IDLE);
  assign busy      = (state_r != ST_IDLE);

  // Number of in-bounds lanes for the request currently on the inputs.
  always_comb begin
    diff_s = out_width - dst_x;
    if ((dst_y >= out_height) || (dst_x >= out_width)) begin
      n_in_s = {CW{1'b0}};
    end else if (diff_s >= 16'(SIMD_WIDTH)) begin
      n_in_s = CW'(SIMD_WIDTH);
    end else begin
      n_in_s = diff_s[CW-1:0];
    end
  end

  // Row start address from captured values; product wraps modulo 2^ADDR_WIDTH.
  always_comb begin
    prod_s     = {16'd0, dst_y_r} * {16'd0, width_r};
    prod_ext_s = {{ADDR_WIDTH{1'b0}}, prod_s};
    x_ext_s    = {{ADDR_WIDTH{1'b0}}, dst_x_r};
    row_addr_s = base_r + prod_ext_s[ADDR_WIDTH-1:0] + x_ext_s[ADDR_WIDTH-1:0];
  end

  // Following lane index, its address offset and its pixel.
  always_comb begin
    lane_plus_s = lane_r + CW'(1);
    lane_ext_s  = {{ADDR_WIDTH{1'b0}}, lane_plus_s};
    pix_plus_s  = 8'd0;
    for (int k = 0; k < SIMD_WIDTH; k++) begin
      if (lane_plus_s == CW'(k)) begin
        pix_plus_s = pix_r[k];
      end else begin
        pix_plus_s = pix_plus_s;
      end
    end
  end

  // Next-state and next registered-output logic.
  always_comb begin
    state_nxt_s    = state_r;
    capture_s      = 1'b0;
    lane_nxt_s     = lane_r;
    row_addr_nxt_s = row_addr_r;
    we_nxt_s       = mem_write_en;
    addr_nxt_s     = mem_addr;
    wdata_nxt_s    = mem_wdata;
    done_nxt_s     = 1'b0;
    clipped_nxt_s  = clipped;
    case (state_r)
      ST_IDLE: begin
        if (req_valid) begin
          capture_s   = 1'b1;
          state_nxt_s = ST_ADDR;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ADDR: begin
        row_addr_nxt_s = row_addr_s;
        lane_nxt_s     = {CW{1'b0}};
        if (n_r == {CW{1'b0}}) begin
          state_nxt_s   = ST_DONE;
          done_nxt_s    = 1'b1;
          clipped_nxt_s = 1'b1;
          we_nxt_s      = 1'b0;
        end else begin
          // Lane 0 is presented straight away so writes start the next cycle.
          state_nxt_s = ST_WRITE;
          we_nxt_s    = 1'b1;
          addr_nxt_s  = row_addr_s;
          wdata_nxt_s = pix_r[0];
        end
      end
      ST_WRITE: begin
        if (mem_write_en && !mem_wait) begin
          lane_nxt_s = lane_plus_s;
          if (lane_r == (n_r - CW'(1))) begin
            state_nxt_s   = ST_DONE;
            we_nxt_s      = 1'b0;
            done_nxt_s    = 1'b1;
            clipped_nxt_s = (n_r < CW'(SIMD_WIDTH));
          end else begin
            addr_nxt_s  = row_addr_r + lane_ext_s[ADDR_WIDTH-1:0];
            wdata_nxt_s = pix_plus_s;
          end
        end else begin
          // Stalled: everything presented stays put.
          state_nxt_s = ST_WRITE;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
        we_nxt_s    = 1'b0;
      end
    endcase
  end

  // State, lane counter and registered memory/status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      lane_r       <= {CW{1'b0}};
      row_addr_r   <= {ADDR_WIDTH{1'b0}};
      mem_write_en <= 1'b0;
      mem_addr     <= {ADDR_WIDTH{1'b0}};
      mem_wdata    <= 8'd0;
      store_done   <= 1'b0;
      clipped      <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      lane_r       <= lane_nxt_s;
      row_addr_r   <= row_addr_nxt_s;
      mem_write_en <= we_nxt_s;
      mem_addr     <= addr_nxt_s;
      mem_wdata    <= wdata_nxt_s;
      store_done   <= done_nxt_s;
      clipped      <= clipped_nxt_s;
    end
  end

  // Request capture; only loaded on an accepted handshake, frozen while busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < SIMD_WIDTH; k++) begin
        pix_r[k] <= 8'd0;
      end
      dst_x_r <= 16'd0;
      dst_y_r <= 16'd0;
      base_r  <= {ADDR_WIDTH{1'b0}};
      width_r <= 16'd0;
      n_r     <= {CW{1'b0}};
    end else if (capture_s) begin
      for (int k = 0; k < SIMD_WIDTH; k++) begin
        pix_r[k] <= pix_in[k];
      end
      dst_x_r <= dst_x;
      dst_y_r <= dst_y;
      base_r  <= img_base_addr;
      width_r <= out_width;
      n_r     <= n_in_s;
    end else begin
      dst_x_r <= dst_x_r;
    end
  end

endmodule

// File: tb/tb_dsa_pixel_store_simd.sv
module tb_dsa_pixel_store_simd;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  pix [0:3];
  logic [15:0] dst_x, dst_y;
  logic [17:0] img_base_addr;
  logic [15:0] out_width, out_height;
  logic        mem_write_en;
  logic [17:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_wait;
  logic        store_done;
  logic        clipped;
  logic        busy;

  int total = 0;
  int bad   = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  int hi_cnt = 0;
  int wr0, dn0;

  dsa_pixel_store_simd #(.ADDR_WIDTH(18), .SIMD_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .pix_in(pix), .dst_x(dst_x), .dst_y(dst_y), .img_base_addr(img_base_addr),
    .out_width(out_width), .out_height(out_height),
    .mem_write_en(mem_write_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wait(mem_wait), .store_done(store_done), .clipped(clipped), .busy(busy)
  );

  always #5 clk = ~clk;

  // Count accepted writes, writes to addresses 10/11, and done pulses.
  always @(posedge clk) begin
    if (!rst && mem_write_en && !mem_wait) begin
      wr_cnt++;
      if (mem_addr == 18'd10 || mem_addr == 18'd11) hi_cnt++;
    end
    if (!rst && store_done) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_w(input string tag, input logic [17:0] a, input logic [7:0] d);
    chk({tag, "_we"}, {31'd0, mem_write_en}, 32'd1);
    chk({tag, "_addr"}, {14'd0, mem_addr}, {14'd0, a});
    chk({tag, "_data"}, {24'd0, mem_wdata}, {24'd0, d});
  endtask

  task automatic set_req(input logic [17:0] b, input logic [15:0] w, input logic [15:0] h,
                         input logic [15:0] x, input logic [15:0] y, input logic [31:0] p);
    img_base_addr = b; out_width = w; out_height = h; dst_x = x; dst_y = y;
    pix[0] = p[31:24]; pix[1] = p[23:16]; pix[2] = p[15:8]; pix[3] = p[7:0];
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; mem_wait = 1'b0;
    set_req(18'd0, 16'd0, 16'd0, 16'd0, 16'd0, 32'd0);
    repeat (2) @(negedge clk);
    chk("rst_we", {31'd0, mem_write_en}, 32'd0);
    chk("rst_addr", {14'd0, mem_addr}, 32'd0);
    chk("rst_wdata", {24'd0, mem_wdata}, 32'd0);
    chk("rst_done", {31'd0, store_done}, 32'd0);
    chk("rst_clipped", {31'd0, clipped}, 32'd0);
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;

    // Unclipped group
    @(negedge clk);
    wr0 = wr_cnt;
    set_req(18'h100, 16'd16, 16'd8, 16'd4, 16'd2, 32'h11223344);
    req_valid = 1'b1;
    @(negedge clk);
    chk("t1_ready", {31'd0, req_ready}, 32'd0);
    chk("t1_busy", {31'd0, busy}, 32'd1);
    chk("t1_we0", {31'd0, mem_write_en}, 32'd0);
    req_valid = 1'b0;
    @(negedge clk); chk_w("t1_l0", 18'h124, 8'h11);
    @(negedge clk); chk_w("t1_l1", 18'h125, 8'h22);
    @(negedge clk); chk_w("t1_l2", 18'h126, 8'h33);
    @(negedge clk); chk_w("t1_l3", 18'h127, 8'h44);
    @(negedge clk);
    chk("t1_done", {31'd0, store_done}, 32'd1);
    chk("t1_clipped", {31'd0, clipped}, 32'd0);
    chk("t1_we_off", {31'd0, mem_write_en}, 32'd0);
    @(negedge clk);
    chk("t1_done_off", {31'd0, store_done}, 32'd0);
    chk("t1_ready_back", {31'd0, req_ready}, 32'd1);
    chk("t1_wr_cnt", wr_cnt - wr0, 32'd4);

    // Right-edge clip
    wr0 = wr_cnt;
    set_req(18'd0, 16'd10, 16'd8, 16'd8, 16'd0, 32'hA1A2A3A4);
    req_valid = 1'b1;
    @(negedge clk); req_valid = 1'b0;
    @(negedge clk); chk_w("t2_l0", 18'd8, 8'hA1);
    @(negedge clk); chk_w("t2_l1", 18'd9, 8'hA2);
    @(negedge clk);
    chk("t2_done", {31'd0, store_done}, 32'd1);
    chk("t2_clipped", {31'd0, clipped}, 32'd1);
    chk("t2_we_off", {31'd0, mem_write_en}, 32'd0);
    @(negedge clk);
    chk("t2_wr_cnt", wr_cnt - wr0, 32'd2);
    chk("t2_no_hi_addr", hi_cnt, 32'd0);

    // Fully out of bounds (dst_y == out_height)
    wr0 = wr_cnt;
    set_req(18'd0, 16'd16, 16'd8, 16'd0, 16'd8, 32'h01020304);
    req_valid = 1'b1;
    @(negedge clk); req_valid = 1'b0;
    chk("t3_we_a", {31'd0, mem_write_en}, 32'd0);
    chk("t3_done_a", {31'd0, store_done}, 32'd0);
    @(negedge clk);
    chk("t3_done", {31'd0, store_done}, 32'd1);
    chk("t3_clipped", {31'd0, clipped}, 32'd1);
    chk("t3_we_b", {31'd0, mem_write_en}, 32'd0);
    @(negedge clk);
    chk("t3_ready", {31'd0, req_ready}, 32'd1);
    chk("t3_wr_cnt", wr_cnt - wr0, 32'd0);

    // Stall on lane 1 for three cycles
    wr0 = wr_cnt;
    set_req(18'h200, 16'd16, 16'd8, 16'd4, 16'd2, 32'h55667788);
    req_valid = 1'b1;
    @(negedge clk); req_valid = 1'b0;
    @(negedge clk); chk_w("t4_l0", 18'h224, 8'h55);
    @(negedge clk); chk_w("t4_l1", 18'h225, 8'h66); mem_wait = 1'b1;
    @(negedge clk); chk_w("t4_hold1", 18'h225, 8'h66);
    @(negedge clk); chk_w("t4_hold2", 18'h225, 8'h66);
    @(negedge clk); chk_w("t4_hold3", 18'h225, 8'h66);
    chk("t4_no_done_stall", {31'd0, store_done}, 32'd0);
    mem_wait = 1'b0;
    @(negedge clk); chk_w("t4_l2", 18'h226, 8'h77);
    @(negedge clk); chk_w("t4_l3", 18'h227, 8'h88);
    @(negedge clk);
    chk("t4_done", {31'd0, store_done}, 32'd1);
    chk("t4_clipped", {31'd0, clipped}, 32'd0);
    @(negedge clk);
    chk("t4_wr_cnt", wr_cnt - wr0, 32'd4);

    // Reset while lane 2 is presented
    wr0 = wr_cnt; dn0 = done_cnt;
    set_req(18'd0, 16'd16, 16'd8, 16'd0, 16'd0, 32'h01020304);
    req_valid = 1'b1;
    @(negedge clk); req_valid = 1'b0;
    @(negedge clk); chk_w("t5_l0", 18'd0, 8'h01);
    @(negedge clk); chk_w("t5_l1", 18'd1, 8'h02);
    @(negedge clk); chk_w("t5_l2", 18'd2, 8'h03); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("t5_we_off", {31'd0, mem_write_en}, 32'd0);
    chk("t5_ready", {31'd0, req_ready}, 32'd1);
    chk("t5_busy", {31'd0, busy}, 32'd0);
    repeat (4) @(negedge clk);
    chk("t5_wr_cnt", wr_cnt - wr0, 32'd2);
    chk("t5_no_done", done_cnt - dn0, 32'd0);
    set_req(18'h10, 16'd16, 16'd8, 16'd4, 16'd1, 32'hB1B2B3B4);
    req_valid = 1'b1;
    @(negedge clk); req_valid = 1'b0;
    @(negedge clk); chk_w("t5b_l0", 18'h24, 8'hB1);
    @(negedge clk); chk_w("t5b_l1", 18'h25, 8'hB2);
    @(negedge clk); chk_w("t5b_l2", 18'h26, 8'hB3);
    @(negedge clk); chk_w("t5b_l3", 18'h27, 8'hB4);
    @(negedge clk);
    chk("t5b_done", {31'd0, store_done}, 32'd1);
    chk("t5b_clipped", {31'd0, clipped}, 32'd0);
    @(negedge clk);

    // Back-to-back with req_valid held high
    set_req(18'd0, 16'd16, 16'd8, 16'd0, 16'd3, 32'hC1C2C3C4);
    req_valid = 1'b1;
    @(negedge clk);
    set_req(18'h3FF, 16'd99, 16'd99, 16'd1, 16'd1, 32'hEEEEEEEE);
    @(negedge clk); chk_w("t6_l0", 18'h30, 8'hC1);
    @(negedge clk); chk_w("t6_l1", 18'h31, 8'hC2);
    pix[2] = 8'h5A;
    @(negedge clk); chk_w("t6_l2", 18'h32, 8'hC3);
    @(negedge clk); chk_w("t6_l3", 18'h33, 8'hC4);
    @(negedge clk);
    chk("t6_done", {31'd0, store_done}, 32'd1);
    chk("t6_ready_in_done", {31'd0, req_ready}, 32'd0);
    set_req(18'd0, 16'd16, 16'd8, 16'd12, 16'd3, 32'hF1F2F3F4);
    @(negedge clk);
    chk("t6_ready_after", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    chk("t6_accepted2", {31'd0, busy}, 32'd1);
    req_valid = 1'b0;
    set_req(18'd0, 16'd0, 16'd0, 16'd0, 16'd0, 32'd0);
    @(negedge clk); chk_w("t6b_l0", 18'h3C, 8'hF1);
    @(negedge clk); chk_w("t6b_l1", 18'h3D, 8'hF2);
    @(negedge clk); chk_w("t6b_l2", 18'h3E, 8'hF3);
    @(negedge clk); chk_w("t6b_l3", 18'h3F, 8'hF4);
    @(negedge clk);
    chk("t6b_done", {31'd0, store_done}, 32'd1);
    chk("t6b_clipped", {31'd0, clipped}, 32'd0);
    repeat (2) @(negedge clk);
    chk("t6_idle_end", {31'd0, req_ready}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
